alu_req_arbiter: RTL
====================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one ALU_TOP instance between two requesters. Round-robin arbitration; valid/ready
//  on each request and on the single response channel. Drives ALU_TOP A/B/ALU_FUNC, waits
//  out the ALU's registered latency, then captures the result selected by ALU_FUNC[3:2].
//  One operation in flight at a time.
// PARAMETERS
//  IN_DATA_WIDTH   16                 operand width (matches ALU_TOP)
//  Arith_OUT_WIDTH 2*IN_DATA_WIDTH    arithmetic result width; also response data width
// PORTS
//  CLK        in   1        clock, all logic on rising edge
//  RST        in   1        reset, synchronous, active-high
//  REQ0_VALID in   1        requester 0 has a command
//  REQ0_READY out  1        requester 0 command accepted this cycle
//  REQ0_A/B   in   IN_DATA_WIDTH  requester 0 operands (signed)
//  REQ0_FUNC  in   4        requester 0 ALU_FUNC
//  REQ1_*     --   --       same set for requester 1
//  ALU_A/B    out  IN_DATA_WIDTH  operands to ALU_TOP
//  ALU_FUNC   out  4        function code to ALU_TOP
//  Arith_OUT  in   Arith_OUT_WIDTH; Carry_OUT in 1; Logic_OUT/SHIFT_OUT in IN_DATA_WIDTH;
//  CMP_OUT    in   3;  Arith_Flag/Logic_Flag/SHIFT_Flag/CMP_Flag in 1   ALU_TOP results
//  RSP_VALID  out  1        response held valid until RSP_READY
//  RSP_READY  in   1        consumer accepts response
//  RSP_ID     out  1        requester index owning the response
//  RSP_DATA   out  Arith_OUT_WIDTH  captured result
//  RSP_CARRY  out  1        captured Carry_OUT (arith only, else 0)
//  RSP_ERR    out  1        selected unit flag was low at capture
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE. Encoding free; one-hot or binary.
//  - IDLE: if any REQx_VALID, grant one; REQx_READY=1 for the granted one only, combinationally
//    in IDLE. Latch A/B/FUNC/ID on that edge; go ISSUE. No valid -> stay IDLE.
//  - Round-robin: both valid -> grant the requester NOT granted last. LAST_GNT resets to 1
//    (requester 0 wins first contention). Single valid -> granted regardless of LAST_GNT.
//  - ISSUE (1 cycle): ALU_A/B/FUNC driven from latched command; ALU registers on this edge.
//  - CAPTURE (1 cycle): ALU_A/B/FUNC still held; sample result by latched FUNC[3:2]:
//    00 Arith_OUT (signed, full width), Carry_OUT, flag Arith_Flag;
//    01 Logic_OUT zero-extended, flag Logic_Flag; 10 CMP_OUT zero-extended, flag CMP_Flag;
//    11 SHIFT_OUT zero-extended, flag SHIFT_Flag. RSP_CARRY=0 for non-arith.
//    RSP_ERR = ~selected flag. Go RESP with RSP_VALID=1 from next cycle.
//  - RESP: RSP_VALID/ID/DATA/CARRY/ERR stable until RSP_READY=1; on that edge -> IDLE,
//    RSP_VALID=0. No new grant in the same cycle as response acceptance (next grant earliest
//    the following cycle). Both REQx_READY=0 outside IDLE.
//  - Latency: grant edge N -> RSP_VALID high in cycle N+3 (first cycle after CAPTURE edge);
//    back-to-back throughput 1 op per 4 cycles with RSP_READY tied high.
//  - Outside ISSUE/CAPTURE, ALU_A/B/FUNC keep last driven values (no glitching to ALU).
//  - Reset (any state, mid-operation included): state=IDLE, REQx_READY=0, RSP_VALID=0,
//    RSP_ID=0, RSP_DATA=0, RSP_CARRY=0, RSP_ERR=0, ALU_A/B=0, ALU_FUNC=0, LAST_GNT=1.
//    An in-flight command is dropped with no response. RST must also reset ALU_TOP.
//  - REQx inputs sampled only on the grant edge; changes afterwards have no effect.
// TESTING
//  1. Reset mid-ISSUE with REQ0 in flight -> next cycle IDLE, RSP_VALID=0, all outputs 0.
//  2. REQ0 A=7,B=-3,FUNC=4'b0010 (arith mul) -> RSP_DATA=32'hFFFF_FFEB, ID=0, valid at N+3.
//  3. REQ0 and REQ1 valid together for 3 ops each, RSP_READY=1 -> grants 0,1,0,1,0,1.
//  4. REQ1 logic A=16'hF0F0,B=16'h0FF0,FUNC=4'b0100 -> RSP_DATA=32'h0000_00F0 (AND), ERR=0.
//  5. RSP_READY low 5 cycles -> RSP_VALID/DATA stable, REQx_READY=0 throughout, no new grant.
//  6. Force selected ALU flag low at CAPTURE -> RSP_ERR=1 with data still captured.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//   Shares a single ALU_TOP between two requesters. Round-robin arbitration,
//   one operation in flight, valid/ready handshakes on both request ports and
//   on the single response channel.
//
//   Flow: IDLE (grant) -> ISSUE (ALU registers operands) -> CAPTURE (sample the
//   unit selected by ALU_FUNC[3:2]) -> RESP (hold until RSP_READY) -> IDLE.
//
// Ports
//   CLK, RST                 rising-edge clock, synchronous active-high reset
//   REQn_VALID / REQn_READY  request handshake; READY is combinational in IDLE
//   REQn_A / REQn_B          signed operands, sampled only on the grant edge
//   REQn_FUNC                ALU_FUNC for the request
//   ALU_A / ALU_B / ALU_FUNC registered command to ALU_TOP, held between ops
//   Arith_OUT .. CMP_Flag    ALU_TOP results and per-unit flags
//   RSP_VALID / RSP_READY    response handshake, payload held while stalled
//   RSP_ID                   index of the requester owning the response
//   RSP_DATA                 captured result (non-arith results zero-extended)
//   RSP_CARRY                captured Carry_OUT for arith, else 0
//   RSP_ERR                  selected unit flag was low at capture
// ---------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int unsigned IN_DATA_WIDTH   = 16,
  parameter int unsigned Arith_OUT_WIDTH = 2 * IN_DATA_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RST,

  input  logic                       REQ0_VALID,
  output logic                       REQ0_READY,
  input  logic [IN_DATA_WIDTH-1:0]   REQ0_A,
  input  logic [IN_DATA_WIDTH-1:0]   REQ0_B,
  input  logic [3:0]                 REQ0_FUNC,

  input  logic                       REQ1_VALID,
  output logic                       REQ1_READY,
  input  logic [IN_DATA_WIDTH-1:0]   REQ1_A,
  input  logic [IN_DATA_WIDTH-1:0]   REQ1_B,
  input  logic [3:0]                 REQ1_FUNC,

  output logic [IN_DATA_WIDTH-1:0]   ALU_A,
  output logic [IN_DATA_WIDTH-1:0]   ALU_B,
  output logic [3:0]                 ALU_FUNC,

  input  logic [Arith_OUT_WIDTH-1:0] Arith_OUT,
  input  logic                       Carry_OUT,
  input  logic [IN_DATA_WIDTH-1:0]   Logic_OUT,
  input  logic [IN_DATA_WIDTH-1:0]   SHIFT_OUT,
  input  logic [2:0]                 CMP_OUT,
  input  logic                       Arith_Flag,
  input  logic                       Logic_Flag,
  input  logic                       SHIFT_Flag,
  input  logic                       CMP_Flag,

  output logic                       RSP_VALID,
  input  logic                       RSP_READY,
  output logic                       RSP_ID,
  output logic [Arith_OUT_WIDTH-1:0] RSP_DATA,
  output logic                       RSP_CARRY,
  output logic                       RSP_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  state_t state;
  state_t state_nxt;

  logic   last_gnt;   // requester granted most recently; 1 after reset so 0 wins first contention
  logic   cmd_id;     // owner of the operation in flight
  logic   gnt_valid;
  logic   gnt_id;

  logic [Arith_OUT_WIDTH-1:0] cap_data;
  logic                       cap_carry;
  logic                       cap_flag;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (gnt_valid) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (RSP_READY) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Grant decode: only in IDLE and never while reset is asserted
  always_comb begin
    gnt_valid  = 1'b0;
    gnt_id     = 1'b0;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    if ((state == ST_IDLE) && !RST) begin
      if (REQ0_VALID && REQ1_VALID) begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_gnt;
      end else if (REQ0_VALID) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (REQ1_VALID) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
      REQ0_READY = gnt_valid && !gnt_id;
      REQ1_READY = gnt_valid &&  gnt_id;
    end
  end

  // Result select by the function-unit field of the latched command
  always_comb begin
    cap_data  = '0;
    cap_carry = 1'b0;
    cap_flag  = 1'b0;
    case (ALU_FUNC[3:2])
      UNIT_ARITH: begin
        cap_data  = Arith_OUT;
        cap_carry = Carry_OUT;
        cap_flag  = Arith_Flag;
      end
      UNIT_LOGIC: begin
        cap_data = Arith_OUT_WIDTH'(Logic_OUT);
        cap_flag = Logic_Flag;
      end
      UNIT_CMP: begin
        cap_data = Arith_OUT_WIDTH'(CMP_OUT);
        cap_flag = CMP_Flag;
      end
      UNIT_SHIFT: begin
        cap_data = Arith_OUT_WIDTH'(SHIFT_OUT);
        cap_flag = SHIFT_Flag;
      end
      default: begin
        cap_data  = '0;
        cap_carry = 1'b0;
        cap_flag  = 1'b0;
      end
    endcase
  end

  // Command latch toward the ALU; values persist until the next grant
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_gnt <= 1'b1;
      cmd_id   <= 1'b0;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUNC <= '0;
    end else if (gnt_valid) begin
      last_gnt <= gnt_id;
      cmd_id   <= gnt_id;
      ALU_A    <= gnt_id ? REQ1_A    : REQ0_A;
      ALU_B    <= gnt_id ? REQ1_B    : REQ0_B;
      ALU_FUNC <= gnt_id ? REQ1_FUNC : REQ0_FUNC;
    end
  end

  // Response registers: loaded on the CAPTURE edge, held while RSP_READY is low
  always_ff @(posedge CLK) begin
    if (RST) begin
      RSP_VALID <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_DATA  <= '0;
      RSP_CARRY <= 1'b0;
      RSP_ERR   <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      RSP_VALID <= 1'b1;
      RSP_ID    <= cmd_id;
      RSP_DATA  <= cap_data;
      RSP_CARRY <= cap_carry;
      RSP_ERR   <= ~cap_flag;
    end else if ((state == ST_RESP) && RSP_READY) begin
      RSP_VALID <= 1'b0;
    end
  end

endmodule
